// File: rtl/handshake_receiver.sv
// Receiving end of the rdy/ack byte handshake. Each accepted byte goes into a small FIFO.
// Local logic reads the FIFO through a show-ahead port. The sender is stalled while the FIFO is full.
module handshake_receiver #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ACK_LEN = 1,
  parameter int unsigned REL_TO  = 15,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy_i,
  input  logic [7:0]        data_i,
  output logic              ack_o,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              proto_err
);

  localparam int unsigned AckW = $clog2(ACK_LEN + 1);
  localparam int unsigned TmoW = $clog2(REL_TO + 2);
  localparam logic [AckW-1:0]   AckLen   = AckW'(ACK_LEN);
  localparam logic [TmoW-1:0]   RelTo    = TmoW'(REL_TO);
  localparam logic [TmoW-1:0]   RelToSat = TmoW'(REL_TO + 1);
  localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StAck     = 2'b01,
    StRelease = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic [AckW-1:0]   ack_cnt_q, ack_cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        mem_q [DEPTH];
  logic              push, pop;

  // Full/empty derive only from the registered count, so rd_en never gates this cycle's push.
  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign ack_o   = ack_q;
  assign pop     = rd_en && !empty;
  assign rd_data = empty ? 8'd0 : mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    ack_cnt_d = ack_cnt_q;
    tmo_d     = tmo_q;
    push      = 1'b0;
    proto_err = 1'b0;
    case (state_q)
      StIdle: begin
        ack_d = 1'b0;
        if (rdy_i && !full) begin
          push      = 1'b1;
          ack_d     = 1'b1;
          ack_cnt_d = AckW'(1);
          state_d   = StAck;
        end
      end
      StAck: begin
        if (!rdy_i) begin
          proto_err = 1'b1;
          ack_d     = 1'b0;
          state_d   = StIdle;
        end else if (ack_cnt_q == AckLen) begin
          ack_d   = 1'b0;
          tmo_d   = '0;
          state_d = StRelease;
        end else begin
          ack_cnt_d = ack_cnt_q + AckW'(1);
        end
      end
      StRelease: begin
        ack_d = 1'b0;
        if (!rdy_i) begin
          state_d = StIdle;
        end else begin
          // Saturating one past the limit keeps the timeout to a single pulse.
          if (tmo_q == RelTo) proto_err = 1'b1;
          if (tmo_q != RelToSat) tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ack_q     <= 1'b0;
      ack_cnt_q <= '0;
      tmo_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      ack_cnt_q <= ack_cnt_d;
      tmo_q     <= tmo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset; empty masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: tb/tb_handshake_receiver.sv
// Directed bench for handshake_receiver. It runs a vector table for the single-byte and fill/stall cases.
// Hand-written sequences cover streaming, protocol errors, release timeout and async reset.
module tb_handshake_receiver;

  logic       clk, rst_n, rdy, rd_en;
  logic [7:0] data;
  logic       ack, empty, full, err;
  logic [7:0] rd;
  logic [2:0] cnt;
  logic       ack3, empty3, full3, err3;
  logic [7:0] rd3;
  logic [2:0] cnt3;

  int n_vec = 0;
  int n_bad = 0;

  handshake_receiver #(.DEPTH(4), .ACK_LEN(1), .REL_TO(15)) dut (
    .clk(clk), .rst_n(rst_n), .rdy_i(rdy), .data_i(data), .ack_o(ack), .rd_en(rd_en),
    .rd_data(rd), .empty(empty), .full(full), .count(cnt), .proto_err(err)
  );

  handshake_receiver #(.DEPTH(4), .ACK_LEN(3), .REL_TO(15)) dut3 (
    .clk(clk), .rst_n(rst_n), .rdy_i(rdy), .data_i(data), .ack_o(ack3), .rd_en(rd_en),
    .rd_data(rd3), .empty(empty3), .full(full3), .count(cnt3), .proto_err(err3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       rd_en;
    logic       ack;
    logic [2:0] cnt;
    logic       empty;
    logic       full;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] d, input logic e);
    rdy = r; data = d; rd_en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; rdy = 1'b0; rd_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int first_c, pulses;
    logic [7:0] b;
    clk = 0; rst_n = 0; rdy = 0; data = 0; rd_en = 0;

    // Single byte
    vecs.push_back('{1'b1, 8'hA5, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'hA5});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00});
    // Fill with 01..04
    for (int k = 1; k <= 4; k++) begin
      vecs.push_back('{1'b1, 8'(k), 1'b0, 1'b1, 3'(k), 1'b0, k == 4, 8'h01});
      vecs.push_back('{1'b1, 8'hEE, 1'b0, 1'b0, 3'(k), 1'b0, k == 4, 8'h01});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'(k), 1'b0, k == 4, 8'h01});
    end
    // Fifth byte stalls, pop in the same cycle does not admit it, taken next cycle
    vecs.push_back('{1'b1, 8'h05, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 8'h01});
    vecs.push_back('{1'b1, 8'h05, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 8'h01});
    vecs.push_back('{1'b1, 8'h05, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 8'h02});
    vecs.push_back('{1'b1, 8'h05, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 8'h02});
    vecs.push_back('{1'b1, 8'h99, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 8'h02});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 8'h02});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 8'h03});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 8'h04});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 8'h05});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00});

    #3;
    chk("reset ack", ack, 0);
    chk("reset count", cnt, 0);
    chk("reset empty", empty, 1);
    chk("reset full", full, 0);
    chk("reset rd_data", rd, 0);
    chk("reset err", err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      rdy = vecs[i].rdy; data = vecs[i].data; rd_en = vecs[i].rd_en;
      #1;
      chk($sformatf("v%0d err", i), err, 0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ack", i), ack, vecs[i].ack);
      chk($sformatf("v%0d count", i), cnt, vecs[i].cnt);
      chk($sformatf("v%0d empty", i), empty, vecs[i].empty);
      chk($sformatf("v%0d full", i), full, vecs[i].full);
      chk($sformatf("v%0d rd_data", i), rd, vecs[i].rd);
    end

    // Stream 16 bytes with rd_en held high; pointers wrap several times
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      b = 8'(8'h30 + i * 7);
      step(1'b1, b, 1'b1);
      chk($sformatf("stream%0d rd_data", i), rd, b);
      chk($sformatf("stream%0d count push", i), cnt, 1);
      step(1'b1, 8'h00, 1'b1);
      chk($sformatf("stream%0d count pop", i), cnt, 0);
      step(1'b0, 8'h00, 1'b1);
    end

    // rdy_i dropped during a 3-cycle ack
    reset_dut();
    step(1'b1, 8'h3C, 1'b0);
    chk("viol ack1", ack3, 1);
    step(1'b1, 8'h00, 1'b0);
    chk("viol ack2", ack3, 1);
    rdy = 1'b0;
    #1;
    chk("viol err pulse", err3, 1);
    @(posedge clk);
    #1;
    chk("viol ack dropped", ack3, 0);
    chk("viol err one cycle", err3, 0);
    chk("viol count", cnt3, 1);
    chk("viol byte kept", rd3, 8'h3C);
    step(1'b1, 8'h4D, 1'b0);
    chk("viol idle accepts", ack3, 1);
    chk("viol count2", cnt3, 2);

    // rdy_i stuck high: single push, one timeout pulse
    reset_dut();
    step(1'b1, 8'h77, 1'b0);
    first_c = 0;
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (err) begin
        pulses++;
        if (first_c == 0) first_c = c;
      end
    end
    chk("stuck pulses", pulses, 1);
    chk("stuck pulse cycle", first_c, 16);
    chk("stuck count", cnt, 1);
    chk("stuck ack", ack, 0);

    // Async reset while ack is high with two bytes held
    reset_dut();
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    chk("rst pre ack", ack, 1);
    chk("rst pre count", cnt, 2);
    rst_n = 1'b0;
    #1;
    chk("rst ack", ack, 0);
    chk("rst count", cnt, 0);
    chk("rst empty", empty, 1);
    chk("rst full", full, 0);
    chk("rst rd_data", rd, 0);
    rdy = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
